window_line_buf: RTL and testbench

WINDOW_LINE_BUF -- requirements
Module: window_line_buf

---
 rtl/win_buf_pkg.sv | 22 ++
 rtl/win_line_ring.sv | 66 ++++++
 rtl/window_line_buf.sv | 124 ++++++++++++
 tb/tb_window_line_buf.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/win_buf_pkg.sv
// Shared state encoding, default geometry and counter-width helper for the
// sliding-window line buffer.
package win_buf_pkg;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_SCAN,
        ST_LOAD,
        ST_DONE
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_IMG_W  = 28;
    localparam int DEF_IMG_H  = 28;
    localparam int DEF_K      = 5;

    // Bits needed to hold 0..n-1, never fewer than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/win_line_ring.sv
// K-line circular pixel store. Raster writes fill lines in turn; the read taps
// return a KxK window whose row 0 is the oldest line (the next one to be overwritten).
module win_line_ring
    import win_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int K      = DEF_K,
    parameter int COL_W  = cnt_w(IMG_W + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  wr_en_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic [COL_W-1:0]      rd_col_i,
    output logic                  wr_eol_o,
    output logic [K*K*DATA_W-1:0] taps_o
);
    localparam int LINE_W = cnt_w(K);
    localparam int WCOL_W = cnt_w(IMG_W);

    logic [DATA_W-1:0] mem_q [K][IMG_W];
    logic [LINE_W-1:0] wline_q;
    logic [WCOL_W-1:0] wcol_q;

    assign wr_eol_o = (wcol_q == WCOL_W'(IMG_W - 1));

    always_ff @(posedge i_clk) begin
        if (wr_en_i) begin
            mem_q[wline_q][wcol_q] <= wr_data_i;
        end
    end

    // The write line doubles as the ring top: it always points at the oldest line.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wline_q <= '0;
            wcol_q  <= '0;
        end else if (wr_en_i) begin
            if (wr_eol_o) begin
                wcol_q  <= '0;
                wline_q <= (wline_q == LINE_W'(K - 1)) ? '0 : wline_q + 1'b1;
            end else begin
                wcol_q <= wcol_q + 1'b1;
            end
        end
    end

    always_comb begin
        int li;
        int ci;
        li     = 0;
        ci     = 0;
        taps_o = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                li = int'(wline_q) + r;
                if (li >= K) li = li - K;
                ci = int'(rd_col_i) + c;
                if (ci >= IMG_W) ci = IMG_W - 1;
                taps_o[(r*K + c)*DATA_W +: DATA_W] = mem_q[LINE_W'(li)][WCOL_W'(ci)];
            end
        end
    end

endmodule

// File: rtl/window_line_buf.sv
// Streams a raster frame into a K-line ring and emits every KxK window
// (stride 1) through a registered valid/ready output stage.
module window_line_buf
    import win_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int K      = DEF_K
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_W-1:0]     s_axis_data,
    input  logic                  s_axis_valid,
    input  logic                  s_axis_last,
    output logic                  s_axis_ready,
    output logic [K*K*DATA_W-1:0] m_win_data,
    output logic                  m_win_valid,
    input  logic                  m_win_ready,
    output logic                  o_intr,
    output logic                  o_last_err
);
    localparam int PIX_W = cnt_w(IMG_W * IMG_H);
    localparam int COL_W = cnt_w(IMG_W + 1);
    localparam int ROW_W = cnt_w(IMG_H + 1);
    localparam int NCOL  = IMG_W - K + 1;
    localparam int NROW  = IMG_H - K + 1;

    state_e                state_q;
    logic [PIX_W-1:0]      pix_q;
    logic [COL_W-1:0]      col_q;
    logic [ROW_W-1:0]      row_q;
    logic                  vld_q;
    logic                  intr_q;
    logic                  err_q;
    logic [K*K*DATA_W-1:0] win_q;
    logic [K*K*DATA_W-1:0] taps;
    logic                  accept;
    logic                  wr_eol;
    logic                  load;
    logic                  last_hs;
    logic                  frame_end;

    assign s_axis_ready = !i_rst && (state_q == ST_FILL || state_q == ST_LOAD);
    assign accept       = s_axis_valid && s_axis_ready;
    assign frame_end    = (pix_q == PIX_W'(IMG_W * IMG_H - 1));
    // col_q counts windows already loaded this row; NCOL means the row is fully issued.
    assign load    = (state_q == ST_SCAN) && (col_q != COL_W'(NCOL)) && (!vld_q || m_win_ready);
    assign last_hs = (state_q == ST_SCAN) && (col_q == COL_W'(NCOL)) && vld_q && m_win_ready;

    win_line_ring #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .K      (K),
        .COL_W  (COL_W)
    ) u_ring (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .wr_en_i   (accept),
        .wr_data_i (s_axis_data),
        .rd_col_i  (col_q),
        .wr_eol_o  (wr_eol),
        .taps_o    (taps)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_FILL;
            pix_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            vld_q   <= 1'b0;
            win_q   <= '0;
            intr_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            intr_q <= 1'b0;
            if (accept) begin
                pix_q <= pix_q + 1'b1;
                if (s_axis_last != frame_end) err_q <= 1'b1;
            end
            if (load) begin
                win_q <= taps;
                vld_q <= 1'b1;
                col_q <= col_q + 1'b1;
            end else if (vld_q && m_win_ready) begin
                vld_q <= 1'b0;
            end
            case (state_q)
                ST_FILL: begin
                    if (accept && pix_q == PIX_W'(K * IMG_W - 1)) state_q <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (last_hs) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                        if (row_q == ROW_W'(NROW - 1)) begin
                            state_q <= ST_DONE;
                            intr_q  <= 1'b1;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept && wr_eol) state_q <= ST_SCAN;
                end
                ST_DONE: begin
                    state_q <= ST_FILL;
                    pix_q   <= '0;
                    col_q   <= '0;
                    row_q   <= '0;
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    assign m_win_data  = win_q;
    assign m_win_valid = vld_q;
    assign o_intr      = intr_q;
    assign o_last_err  = err_q;

endmodule

// File: tb/tb_window_line_buf.sv
// Bench for window_line_buf: a small 4x4/K=3 instance for directed frames and
// a default 28x28/K=5 instance for back-to-back frames, both against a window model.
module tb_window_line_buf;
    localparam int AW = 4, AH = 4, AK = 3, ANC = AW - AK + 1, AWIN = ANC * (AH - AK + 1);
    localparam int BW = 28, BH = 28, BK = 5, BNC = BW - BK + 1, BWIN = BNC * (BH - BK + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]         a_data = '0;
    logic               a_valid = 1'b0;
    logic               a_last = 1'b0;
    logic               a_ready;
    logic [AK*AK*8-1:0] a_win;
    logic               a_wvalid;
    logic               a_wready = 1'b1;
    logic               a_intr;
    logic               a_err;
    logic               a_toggle = 1'b0;

    logic [7:0]         b_data = '0;
    logic               b_valid = 1'b0;
    logic               b_last = 1'b0;
    logic               b_ready;
    logic [BK*BK*8-1:0] b_win;
    logic               b_wvalid;
    logic               b_wready = 1'b1;
    logic               b_intr;
    logic               b_err;

    int n_chk = 0;
    int n_fail = 0;

    window_line_buf #(.DATA_W(8), .IMG_W(AW), .IMG_H(AH), .K(AK)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .s_axis_data(a_data), .s_axis_valid(a_valid), .s_axis_last(a_last), .s_axis_ready(a_ready),
        .m_win_data(a_win), .m_win_valid(a_wvalid), .m_win_ready(a_wready),
        .o_intr(a_intr), .o_last_err(a_err)
    );

    window_line_buf dut_b (
        .i_clk(clk), .i_rst(rst),
        .s_axis_data(b_data), .s_axis_valid(b_valid), .s_axis_last(b_last), .s_axis_ready(b_ready),
        .m_win_data(b_win), .m_win_valid(b_wvalid), .m_win_ready(b_wready),
        .o_intr(b_intr), .o_last_err(b_err)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic finish_tb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    function automatic logic [7:0] pix_b(input int f, input int i);
        return 8'(i + 37 * f);
    endfunction

    // Window n of a frame: top-left at row n/NCOL, column n%NCOL of the image.
    function automatic logic [AK*AK*8-1:0] exp_a(input int n);
        logic [AK*AK*8-1:0] v;
        int wr, c;
        v  = '0;
        wr = (n % AWIN) / ANC;
        c  = n % ANC;
        for (int r = 0; r < AK; r++)
            for (int cc = 0; cc < AK; cc++)
                v[(r*AK + cc)*8 +: 8] = 8'((wr + r) * AW + c + cc);
        return v;
    endfunction

    function automatic logic [BK*BK*8-1:0] exp_b(input int f, input int n);
        logic [BK*BK*8-1:0] v;
        int wr, c;
        v  = '0;
        wr = n / BNC;
        c  = n % BNC;
        for (int r = 0; r < BK; r++)
            for (int cc = 0; cc < BK; cc++)
                v[(r*BK + cc)*8 +: 8] = pix_b(f, (wr + r) * BW + c + cc);
        return v;
    endfunction

    int a_n = 0, a_tot = 0, a_icnt = 0;
    logic a_stall = 1'b0, a_pintr = 1'b0;
    logic [AK*AK*8-1:0] a_held = '0, a_first = '0, a_lastw = '0;

    always @(negedge clk) begin
        if (rst) begin
            a_n = 0;
            a_stall = 1'b0;
            a_pintr = 1'b0;
        end else begin
            if (a_stall) begin
                check("a_stall_valid", a_wvalid, 1);
                check("a_stall_data", a_win, a_held);
            end
            if (a_wvalid && a_wready) begin
                check("a_window", a_win, exp_a(a_n));
                if (a_n % AWIN == 0) a_first = a_win;
                if (a_n % AWIN == AWIN - 1) a_lastw = a_win;
                a_n++;
                a_tot++;
                a_stall = 1'b0;
            end else begin
                a_stall = a_wvalid;
                a_held = a_win;
            end
            if (a_intr) begin
                check("a_intr_width", a_pintr, 0);
                check("a_intr_at_frame_end", a_n % AWIN, 0);
                a_icnt++;
            end
            a_pintr = a_intr;
        end
    end

    int b_n = 0, b_icnt = 0;
    logic [BK*BK*8-1:0] b_first = '0;

    always @(negedge clk) begin
        if (rst) begin
            b_n = 0;
        end else begin
            if (b_wvalid && b_wready) begin
                check("b_window", b_win, exp_b(b_n / BWIN, b_n % BWIN));
                if (b_n == 0) b_first = b_win;
                b_n++;
            end
            if (b_intr) begin
                check("b_frame_windows", b_n, (b_icnt + 1) * BWIN);
                b_icnt++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            a_wready = a_toggle ? ~a_wready : 1'b1;
        end
    end

    task automatic push_a(input int v, input bit last, input bit gap);
        int t;
        if (gap) begin
            a_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        a_data = 8'(v);
        a_last = last;
        a_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!a_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("a_push_ready", a_ready, 1);
        if (!a_ready) finish_tb();
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_last = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] v, input bit last);
        int t;
        b_data = v;
        b_last = last;
        b_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!b_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!b_ready) begin
            check("b_push_ready", b_ready, 1);
            finish_tb();
        end
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        b_last = 1'b0;
    endtask

    task automatic wait_intr_a(input int target);
        int t;
        t = 0;
        while (a_icnt < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("a_frame_done", a_icnt >= target, 1);
        if (a_icnt < target) finish_tb();
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic ramp_a(input int last_at, input bit gaps);
        for (int i = 0; i < AW * AH; i++) push_a(i, i == last_at, gaps && (i % 2 == 1));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_ready", a_ready, 0);
        check("rst_a_wvalid", a_wvalid, 0);
        check("rst_a_wdata", a_win, 0);
        check("rst_a_intr", a_intr, 0);
        check("rst_a_err", a_err, 0);
        check("rst_b_ready", b_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("release_a_ready", a_ready, 1);
        check("release_b_ready", b_ready, 1);
        @(posedge clk);
        #1;

        // Plain ramp with downstream always ready.
        ramp_a(15, 1'b0);
        wait_intr_a(1);
        check("ramp_windows", a_tot, 4);
        check("ramp_first", a_first, 72'h0a0908060504020100);
        check("ramp_last", a_lastw, 72'h0f0e0d0b0a09070605);
        check("ramp_intr_count", a_icnt, 1);
        check("ramp_err", a_err, 0);

        // Downstream stalls every other cycle, input valid gaps mid-row.
        a_toggle = 1'b1;
        ramp_a(15, 1'b1);
        wait_intr_a(2);
        a_toggle = 1'b0;
        check("stall_windows", a_tot, 8);
        check("stall_first", a_first, 72'h0a0908060504020100);
        check("stall_last", a_lastw, 72'h0f0e0d0b0a09070605);
        check("stall_intr_count", a_icnt, 2);
        check("stall_err", a_err, 0);

        // Misplaced last on pixel 7.
        for (int i = 0; i < AW * AH; i++) begin
            push_a(i, i == 7, 1'b0);
            if (i == 7) check("lasterr_set", a_err, 1);
        end
        wait_intr_a(3);
        check("lasterr_sticky", a_err, 1);
        check("lasterr_windows", a_tot, 12);

        // Reset mid-fill discards the partial frame.
        for (int i = 0; i < 10; i++) push_a(i, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", a_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_err", a_err, 0);
        check("midrst_wvalid", a_wvalid, 0);
        check("midrst_wdata", a_win, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ramp_a(15, 1'b0);
        wait_intr_a(4);
        check("midrst_windows", a_tot, 16);
        check("midrst_first", a_first, 72'h0a0908060504020100);
        check("midrst_last", a_lastw, 72'h0f0e0d0b0a09070605);
        check("midrst_err_after", a_err, 0);

        // Default geometry, two frames back to back.
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < BW * BH; i++) push_b(pix_b(f, i), i == BW * BH - 1);
        for (int t = 0; t < 3000 && b_icnt < 2; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("dflt_intr_count", b_icnt, 2);
        check("dflt_windows", b_n, 2 * BWIN);
        check("dflt_err", b_err, 0);
        check("dflt_first_lane24", b_first[24*8 +: 8], 116);
        finish_tb();
    end

endmodule
